// File: rtl/piso_if.sv
// Valid/ready word input and framed serial output of the parallel-in serial-out stage.
interface piso_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             flush;
  logic             so;
  logic             so_valid;
  logic             so_last;
  logic             busy;

  modport master (
    output din, din_valid, flush,
    input  din_ready, so, so_valid, so_last, busy
  );

  modport slave (
    input  din, din_valid, flush,
    output din_ready, so, so_valid, so_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Accepts a WIDTH-bit word over valid/ready and shifts it out LSB first, one bit per clk,
// with a last-bit strobe and GAP forced idle cycles between frames.
module piso_serializer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 1
) (
  input logic   clk,
  input logic   rst,
  piso_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic [GW-1:0]    gap_q;
  logic             so_q;
  logic             so_valid_q;
  logic             so_last_q;

  assign bus.din_ready = (state_q == StIdle) & ~bus.flush;
  assign bus.busy      = (state_q != StIdle);
  assign bus.so        = so_q;
  assign bus.so_valid  = so_valid_q;
  assign bus.so_last   = so_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sh_q       <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      so_last_q  <= 1'b0;
    end else if (bus.flush) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      so_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.din_valid) begin
            so_q       <= bus.din[0];
            so_valid_q <= 1'b1;
            so_last_q  <= 1'b0;
            sh_q       <= bus.din >> 1;
            cnt_q      <= CW'(1);
            state_q    <= StShift;
          end else begin
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            so_last_q  <= 1'b0;
          end
        end
        StShift: begin
          // so_last_q marks that the final bit is already on so; this edge closes the frame
          if (so_last_q) begin
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            so_last_q  <= 1'b0;
            cnt_q      <= '0;
            if (GAP > 0) begin
              state_q <= StGap;
              gap_q   <= GW'(GAP);
            end else begin
              state_q <= StIdle;
            end
          end else begin
            so_q      <= sh_q[0];
            sh_q      <= sh_q >> 1;
            cnt_q     <= cnt_q + CW'(1);
            so_last_q <= (cnt_q == LastCnt);
          end
        end
        StGap: begin
          so_q       <= 1'b0;
          so_valid_q <= 1'b0;
          so_last_q  <= 1'b0;
          gap_q      <= gap_q - GW'(1);
          if (gap_q <= GW'(1)) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
